// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   Round-robin arbiter for NUM_CH requesters in front of one single-port
//   memory. It runs one memory transaction at a time. Each transaction ends
//   with a one-cycle done pulse on the owning channel. The error pulse marks
//   an illegal request (read and write both set) or a mem_ready timeout.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   en                  arbitration enable (does not abort an in-flight access)
//   req_rd, req_wr      per-channel level requests, held until rsp_done
//   req_addr, req_wdata per-channel address / write data, channel i at [i*W +: W]
//   rsp_rdata           per-channel last read data, same packing
//   rsp_done, rsp_err   per-channel one-cycle completion / error pulses
//   grant               one-hot owner of the current transaction, 0 when idle
//   busy                high whenever the FSM is not in IDLE
//   mem_*               memory control, address, write data, read data, ready
//
// All outputs are registered.

module mem_arbiter_rr #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        req_rd,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH*DATA_W-1:0] rsp_rdata,
  output logic [NUM_CH-1:0]        rsp_done,
  output logic [NUM_CH-1:0]        rsp_err,
  output logic [NUM_CH-1:0]        grant,
  output logic                     busy,
  output logic                     mem_en,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready
);

  localparam int IDX_W = $clog2(NUM_CH);
  // The counter only has to reach TIMEOUT_CYC-1; keep one bit when disabled.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   gidx_reg, gidx_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               rd_op_reg, rd_op_next;
  logic [NUM_CH-1:0]  grant_reg, grant_next;
  logic [NUM_CH-1:0]  done_reg, done_next;
  logic [NUM_CH-1:0]  err_reg, err_next;
  logic               busy_reg, busy_next;
  logic               mem_en_reg, mem_en_next;
  logic               mem_read_reg, mem_read_next;
  logic               mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]  mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0]  rdata_reg [NUM_CH];
  logic               rdata_we;

  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  illegal;
  logic [ADDR_W-1:0]  addr_arr  [NUM_CH];
  logic [DATA_W-1:0]  wdata_arr [NUM_CH];

  // Unpack the flat request buses and pack the read-data registers.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign pending[gi]   = req_rd[gi] | req_wr[gi];
      assign illegal[gi]   = req_rd[gi] & req_wr[gi];
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      assign rsp_rdata[gi*DATA_W +: DATA_W] = rdata_reg[gi];
    end
  endgenerate

  // Round-robin search. The first pending channel at or above ptr wins,
  // wrapping around to channel 0.
  logic               found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   sel_inc;

  always_comb begin : arb
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    sel_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!found && pending[cand_idx]) begin
        found   = 1'b1;
        sel_idx = cand_idx;
      end
    end
    sel_inc = (sel_idx == IDX_W'(NUM_CH - 1)) ? '0 : sel_idx + 1'b1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gidx_next      = gidx_reg;
    cnt_next       = cnt_reg;
    rd_op_next     = rd_op_reg;
    grant_next     = grant_reg;
    done_next      = '0;
    err_next       = '0;
    mem_en_next    = 1'b0;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    rdata_we       = 1'b0;

    case (state_reg)
      IDLE: begin
        grant_next = '0;
        cnt_next   = '0;
        if (en && found) begin
          gidx_next           = sel_idx;
          grant_next[sel_idx] = 1'b1;
          ptr_next            = sel_inc;
          rd_op_next          = req_rd[sel_idx];
          if (illegal[sel_idx]) begin
            // Read+write together is rejected without touching memory.
            state_next         = DONE;
            done_next[sel_idx] = 1'b1;
            err_next[sel_idx]  = 1'b1;
          end else begin
            state_next     = ACCESS;
            mem_en_next    = 1'b1;
            mem_read_next  = req_rd[sel_idx];
            mem_write_next = req_wr[sel_idx];
            mem_addr_next  = addr_arr[sel_idx];
            mem_wdata_next = req_wr[sel_idx] ? wdata_arr[sel_idx] : '0;
          end
        end
      end

      ACCESS: begin
        if (mem_ready) begin
          // Ready wins over a timeout on the same edge.
          state_next          = DONE;
          done_next[gidx_reg] = 1'b1;
          rdata_we            = rd_op_reg;
        end else if ((TIMEOUT_CYC > 0) && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1))) begin
          // This edge ends the TIMEOUT_CYC-th ACCESS cycle without ready.
          state_next          = DONE;
          done_next[gidx_reg] = 1'b1;
          err_next[gidx_reg]  = 1'b1;
        end else begin
          mem_en_next    = 1'b1;
          mem_read_next  = mem_read_reg;
          mem_write_next = mem_write_reg;
          mem_addr_next  = mem_addr_reg;
          mem_wdata_next = mem_wdata_reg;
          if (TIMEOUT_CYC > 0) cnt_next = cnt_reg + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
        grant_next = '0;
        cnt_next   = '0;
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
        cnt_next   = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      gidx_reg      <= '0;
      cnt_reg       <= '0;
      rd_op_reg     <= 1'b0;
      grant_reg     <= '0;
      done_reg      <= '0;
      err_reg       <= '0;
      busy_reg      <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) rdata_reg[i] <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gidx_reg      <= gidx_next;
      cnt_reg       <= cnt_next;
      rd_op_reg     <= rd_op_next;
      grant_reg     <= grant_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
      mem_en_reg    <= mem_en_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if (rdata_we) rdata_reg[gidx_reg] <= mem_rdata;
    end
  end

  assign grant     = grant_reg;
  assign rsp_done  = done_reg;
  assign rsp_err   = err_reg;
  assign busy      = busy_reg;
  assign mem_en    = mem_en_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr. It uses directed scenarios, a transaction-level
// reference model checked on every falling edge, and literal expectations
// for grant order, latency and read data.

module tb_mem_arbiter_rr;

  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TO  = 16;
  localparam int IW  = 2;
  localparam int BA  = NCH * AW;
  localparam int BD  = NCH * DW;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           en        = 1'b0;
  logic [NCH-1:0] req_rd    = '0;
  logic [NCH-1:0] req_wr    = '0;
  logic [BA-1:0]  req_addr  = '0;
  logic [BD-1:0]  req_wdata = '0;
  logic [BD-1:0]  rsp_rdata;
  logic [NCH-1:0] rsp_done, rsp_err, grant;
  logic           busy, mem_en, mem_read, mem_write;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;
  logic           mem_ready = 1'b0;

  mem_arbiter_rr #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_rdata(rsp_rdata), .rsp_done(rsp_done), .rsp_err(rsp_err),
    .grant(grant), .busy(busy),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int ready_delay    = 0;
  bit ready_hold_low = 1'b0;

  function automatic logic [DW-1:0] mem_content(input logic [AW-1:0] a);
    return (a == 8'h10) ? 8'hA5 : a + 8'h33;
  endfunction

  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        mem_rdata = mem_content(mem_addr);
        if (!ready_hold_low && wait_cnt >= ready_delay) mem_ready = 1'b1;
        else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Phase 0 = idle, 1 = memory access, 2 = completion cycle.
  int             m_phase;
  int             m_ptr;
  int             m_age;
  logic [IW-1:0]  m_owner;
  bit             m_rd, m_wr, m_err;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wdata;
  logic [DW-1:0]  m_rdata [NCH];

  task automatic m_reset();
    m_phase = 0; m_ptr = 0; m_age = 0; m_owner = '0;
    m_rd = 1'b0; m_wr = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0;
    for (int i = 0; i < NCH; i++) m_rdata[IW'(i)] = '0;
  endtask

  task automatic m_step();
    int            c;
    logic [IW-1:0] ci;
    if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (mem_ready) begin
        m_phase = 2;
        m_err   = 1'b0;
        if (m_rd) m_rdata[m_owner] = mem_rdata;
      end else begin
        m_age++;
        if (TO > 0 && m_age == TO) begin
          m_phase = 2;
          m_err   = 1'b1;
        end
      end
    end else if (en) begin
      for (int k = 0; k < NCH; k++) begin
        c  = (m_ptr + k) % NCH;
        ci = IW'(c);
        if (req_rd[ci] | req_wr[ci]) begin
          m_owner = ci;
          m_ptr   = (c + 1) % NCH;
          m_rd    = req_rd[ci];
          m_wr    = req_wr[ci];
          m_addr  = AW'(req_addr >> (c * AW));
          m_wdata = DW'(req_wdata >> (c * DW));
          if (m_rd && m_wr) begin
            m_phase = 2;
            m_err   = 1'b1;
          end else begin
            m_phase = 1;
            m_err   = 1'b0;
            m_age   = 0;
          end
          break;
        end
      end
    end
  endtask

  initial begin : model
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- compare process + transaction log ----------------
  int done_ch[$];
  int done_err[$];
  int done_men[$];

  initial begin : compare
    logic [NCH-1:0] e_onehot;
    logic [BD-1:0]  e_rdata;
    bit             e_acc;
    int             men_cnt;
    int             d;
    men_cnt = 0;
    forever begin
      @(negedge clk);
      e_onehot = NCH'(1) << m_owner;
      e_acc    = (m_phase == 1);
      e_rdata  = '0;
      for (int i = 0; i < NCH; i++) e_rdata = e_rdata | (BD'(m_rdata[IW'(i)]) << (i * DW));
      chk("grant",     32'(grant),     (m_phase != 0) ? 32'(e_onehot) : 32'd0);
      chk("busy",      32'(busy),      32'(m_phase != 0));
      chk("mem_en",    32'(mem_en),    32'(e_acc));
      chk("mem_read",  32'(mem_read),  32'(e_acc && m_rd));
      chk("mem_write", 32'(mem_write), 32'(e_acc && m_wr));
      chk("mem_addr",  32'(mem_addr),  e_acc ? 32'(m_addr) : 32'd0);
      chk("mem_wdata", 32'(mem_wdata), (e_acc && m_wr) ? 32'(m_wdata) : 32'd0);
      chk("rsp_done",  32'(rsp_done),  (m_phase == 2) ? 32'(e_onehot) : 32'd0);
      chk("rsp_err",   32'(rsp_err),   (m_phase == 2 && m_err) ? 32'(e_onehot) : 32'd0);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
      if (!rst_n) begin
        men_cnt = 0;
      end else if (rsp_done != '0) begin
        d = 0;
        for (int i = 0; i < NCH; i++) if (rsp_done[IW'(i)]) d = i;
        done_ch.push_back(d);
        done_err.push_back(int'(rsp_err[IW'(d)]));
        done_men.push_back(men_cnt);
        $display("txn ch=%0d err=%0b mem_en_cycles=%0d rsp_rdata=%08h t=%0t",
                 d, rsp_err[IW'(d)], men_cnt, rsp_rdata, $time);
        men_cnt = 0;
      end else if (mem_en) begin
        men_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] dat);
    req_rd[IW'(ch)] = rd;
    req_wr[IW'(ch)] = wr;
    req_addr  = (req_addr  & ~(BA'(8'hFF) << (ch * AW))) | (BA'(a)   << (ch * AW));
    req_wdata = (req_wdata & ~(BD'(8'hFF) << (ch * DW))) | (BD'(dat) << (ch * DW));
  endtask

  // Drop each channel's request right after its done pulse; stop once idle.
  task automatic run_until_idle(input int budget, input string tag);
    int cyc;
    cyc = 0;
    forever begin
      tick();
      for (int i = 0; i < NCH; i++) begin
        if (rsp_done[IW'(i)]) begin
          req_rd[IW'(i)] = 1'b0;
          req_wr[IW'(i)] = 1'b0;
        end
      end
      if (req_rd == '0 && req_wr == '0 && !busy) break;
      cyc++;
      if (cyc > budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: still active after %0d cycles, required idle", tag, budget);
        req_rd = '0;
        req_wr = '0;
        break;
      end
    end
  endtask

  task automatic chk_txn(input int idx, input int ch, input int err, input int men, input string tag);
    if (idx >= done_ch.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: transaction %0d not logged, got %0d logged", tag, idx, done_ch.size());
    end else begin
      chk({tag, ".ch"},  32'(done_ch[idx]),  32'(ch));
      chk({tag, ".err"}, 32'(done_err[idx]), 32'(err));
      chk({tag, ".men"}, 32'(done_men[idx]), 32'(men));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int base;
    int order [4];
    int cyc;
    order = '{0, 1, 2, 3};

    // Reset state
    tick(); tick();
    chk("reset.grant", 32'(grant), 32'd0);
    chk("reset.busy",  32'(busy),  32'd0);
    chk("reset.rdata", 32'(rsp_rdata), 32'd0);
    rst_n = 1'b1;
    tick();

    // A: four simultaneous writes, twice; order 0..3 both rounds
    base = done_ch.size();
    en = 1'b1;
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 1'b1, AW'(8'h40 + i), DW'(8'hC0 + i));
    run_until_idle(40, "A1");
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 1'b1, AW'(8'h48 + i), DW'(8'hD0 + i));
    run_until_idle(40, "A2");
    for (int i = 0; i < 8; i++) chk_txn(base + i, order[i % 4], 0, 1, "A.order");
    chk("A.rdata", 32'(rsp_rdata), 32'd0);

    // B: ch2 read at 0x10, ready one cycle after mem_en
    base = done_ch.size();
    set_ch(2, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    chk("B.mem_en",   32'(mem_en),   32'd1);
    chk("B.mem_read", 32'(mem_read), 32'd1);
    chk("B.mem_addr", 32'(mem_addr), 32'h10);
    tick();
    chk("B.done", 32'(rsp_done), 32'h4);
    req_rd[2] = 1'b0;
    tick();
    chk("B.done_off", 32'(rsp_done), 32'h0);
    run_until_idle(10, "B");
    chk_txn(base, 2, 0, 1, "B.txn");
    chk("B.rdata", 32'(rsp_rdata), 32'h00A50000);

    // C: ch1 illegal (rd+wr), ch2 read pending
    base = done_ch.size();
    set_ch(1, 1'b1, 1'b1, 8'h11, 8'h77);
    set_ch(2, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    chk("C.grant",  32'(grant),    32'h2);
    chk("C.mem_en", 32'(mem_en),   32'd0);
    chk("C.done",   32'(rsp_done), 32'h2);
    chk("C.err",    32'(rsp_err),  32'h2);
    req_rd[1] = 1'b0;
    req_wr[1] = 1'b0;
    run_until_idle(20, "C");
    chk_txn(base,     1, 1, 0, "C.first");
    chk_txn(base + 1, 2, 0, 1, "C.second");
    chk("C.rdata", 32'(rsp_rdata), 32'h00530000);

    // D: ch0 read with mem_ready held low -> timeout after 16 ACCESS cycles
    base = done_ch.size();
    ready_hold_low = 1'b1;
    set_ch(0, 1'b1, 1'b0, 8'h30, 8'h00);
    run_until_idle(40, "D");
    ready_hold_low = 1'b0;
    chk_txn(base, 0, 1, 16, "D.txn");
    chk("D.rdata", 32'(rsp_rdata), 32'h00530000);

    // E: en low blocks grants; en high grants ch3; en dropped mid-ACCESS
    base = done_ch.size();
    en = 1'b0;
    set_ch(3, 1'b0, 1'b1, 8'h7E, 8'hEE);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("E.idle_busy",  32'(busy),  32'd0);
      chk("E.idle_grant", 32'(grant), 32'd0);
    end
    ready_delay = 3;
    en = 1'b1;
    tick();
    chk("E.grant", 32'(grant), 32'h8);
    en = 1'b0;
    run_until_idle(20, "E");
    ready_delay = 0;
    en = 1'b1;
    chk_txn(base, 3, 0, 4, "E.txn");

    // F: asynchronous reset in the middle of ACCESS
    ready_hold_low = 1'b1;
    set_ch(1, 1'b1, 1'b0, 8'h50, 8'h00);
    cyc = 0;
    while (!mem_en && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("F.mem_en_seen", 32'(mem_en), 32'd1);
    tick();
    tick();
    base = done_ch.size();
    #2;
    rst_n = 1'b0;
    #1;
    chk("F.rst_grant",  32'(grant),     32'd0);
    chk("F.rst_busy",   32'(busy),      32'd0);
    chk("F.rst_mem_en", 32'(mem_en),    32'd0);
    chk("F.rst_addr",   32'(mem_addr),  32'd0);
    chk("F.rst_rdata",  32'(rsp_rdata), 32'd0);
    tick();
    req_rd = '0;
    req_wr = '0;
    ready_hold_low = 1'b0;
    tick();
    rst_n = 1'b1;
    set_ch(1, 1'b1, 1'b0, 8'h60, 8'h00);
    set_ch(3, 1'b1, 1'b0, 8'h70, 8'h00);
    run_until_idle(20, "F");
    chk("F.txn_count", 32'(done_ch.size() - base), 32'd2);
    chk_txn(base,     1, 0, 1, "F.first");
    chk_txn(base + 1, 3, 0, 1, "F.second");
    chk("F.rdata", 32'(rsp_rdata), 32'hA3009300);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-channel arbiter in front of the single-port memory block; successor to the fixed 4-way, state-selected memory controller.
- Requesters no longer need an external channel-select. The block arbitrates among pending requests in round-robin order and runs one memory transaction at a time.
- It completes each transaction with a per-channel done/error pulse, and adds a timeout on the memory ready handshake.

Parameters:
- NUM_CH, 4, number of requester channels (>=2)
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- TIMEOUT_CYC, 16, cycles in ACCESS without mem_ready before abort; 0 disables the timeout

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  arbitration enable
- req_rd  input  NUM_CH  per-channel read request, level, held until done
- req_wr  input  NUM_CH  per-channel write request, level, held until done
- req_addr  input  NUM_CH*ADDR_W  channel i address at bits [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_CH*DATA_W  channel i write data, same packing
- rsp_rdata  output  NUM_CH*DATA_W  per-channel last read data, same packing
- rsp_done  output  NUM_CH  one-cycle completion pulse for the granted channel
- rsp_err  output  NUM_CH  one-cycle error pulse, always coincident with rsp_done
- grant  output  NUM_CH  one-hot owner of the current transaction; 0 when idle
- busy  output  1  high in any state other than IDLE
- mem_en, mem_read, mem_write  output  1 each  memory control
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- mem_ready  input  1  memory completion

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-transaction):
  - every output goes to 0; rsp_rdata goes to all-0;
  - state goes to IDLE, round-robin pointer goes to 0, timeout counter goes to 0;
  - no done pulse is issued for an aborted transaction.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - A channel is pending when req_rd[i] | req_wr[i].
  - If en=1 and any channel is pending, select the first pending channel searching from ptr upward, wrapping modulo NUM_CH.
  - Register grant, address, write data and operation from the selected channel.
  - Set ptr = (selected+1) mod NUM_CH.
  - If en=0, no grant is made. Requests stay pending and are not lost.
- Illegal request (req_rd[i] & req_wr[i] both set):
  - the channel is granted normally;
  - the block goes directly to DONE with rsp_err set;
  - mem_en stays 0.
- Legal request: go to ACCESS.
  - mem_en=1 and mem_read/mem_write per the operation, from the first ACCESS cycle.
  - mem_addr = latched address.
  - mem_wdata = latched data for a write, 0 for a read.
- ACCESS:
  - On an edge with mem_ready=1: go to DONE. For a read, load mem_rdata into the granted channel's rsp_rdata slice on that edge.
  - Timeout counter increments each ACCESS cycle. If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC with mem_ready low: go to DONE with error; rsp_rdata is unchanged.
  - mem_ready takes priority over timeout when both occur on the same edge.
  - en going low does not abort an in-flight transaction.
- DONE (exactly one cycle):
  - mem_en, mem_read, mem_write = 0.
  - rsp_done[g]=1; rsp_err[g]=1 only for a timeout or an illegal request.
  - grant is held during DONE.
  - Then return to IDLE: grant goes to 0 and the counter clears.
- Requester rule: deassert the request by the edge after rsp_done is sampled. IDLE re-arbitrates one cycle after DONE, so a promptly dropped request is never re-served.
- Latency:
  - Request sampled at edge E; mem_en is high after E.
  - With mem_ready returned at edge E+1, rsp_done is high during E+1..E+2.
  - The next grant is possible at edge E+3.
  - Minimum throughput is 3 cycles per transaction.
- rsp_rdata of a channel changes only on that channel's successful read.
- Fairness: a continuously requesting channel waits at most NUM_CH-1 transactions.

Test Plan:
- Reset, then ch2 read at addr 0x10 holding 0xA5, mem_ready one cycle after mem_en -> mem_en/mem_read/mem_addr=0x10 asserted after the request edge; rsp_done[2] pulses 1 cycle; rsp_rdata slice 2 = 0xA5; the other slices stay 0.
- All 4 channels request writes at the same time, each held until its done -> grant order 0,1,2,3; the next set of 4 simultaneous requests gives order 0,1,2,3 again (ptr wrapped); each mem_wdata matches the granted channel's req_wdata.
- ch1 asserts both req_rd and req_wr -> mem_en never rises; rsp_done[1] and rsp_err[1] pulse together 1 cycle after the grant edge; the next grant goes to ch2 if it is pending.
- ch0 read, mem_ready held low, TIMEOUT_CYC=16 -> exactly 16 ACCESS cycles, then rsp_done[0]=rsp_err[0]=1; rsp_rdata slice 0 unchanged; mem_en low in DONE.
- en=0 with ch3 pending -> no grant and busy=0. en=1 -> ch3 granted. Then drop en mid-ACCESS -> the transaction still completes with rsp_done[3].
- rst_n pulsed low during ACCESS -> all outputs are 0 immediately (asynchronous), no rsp_done is issued, and after release the first grant searches from ch0.
